// File: rtl/spi_device.sv
`default_nettype none
// ============================================================================
//  Module   : spi_device
//  Purpose  : Device end of the 32-bit SPI link (mode 0). Oversamples the
//             controller's spi_clk / spi_cs / spi_mosi in the clk domain,
//             deserialises controller-to-device words LSB-first, and on a
//             local tx request pulses gpio_trigger low and then serialises
//             a word onto spi_miso MSB-first.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             spi_clk/cs/mosi       - SPI inputs from the controller
//             spi_miso              - SPI data back to the controller
//             gpio_trigger          - read request (falling edge = request)
//             tx_data/valid/ready   - word to send to the controller
//             rx_data/valid         - last received word + update pulse
//             rx_is_read            - word completed while a read was shifting
//             rx_err                - cs rose with a partial word
//  Revision : 1.0 - initial release
// ============================================================================
module spi_device #(
   parameter int DATA_W      = 32,
   parameter int SYNC_STAGES = 2,
   parameter int TRIG_LOW    = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_clk,
   input  logic              spi_cs,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              gpio_trigger,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              rx_is_read,
   output logic              rx_err
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam int TIM_W = $clog2(TRIG_LOW + SYNC_STAGES + 1);
   localparam logic [CNT_W-1:0] C_LAST_BIT  = CNT_W'(DATA_W - 1);
   localparam logic [TIM_W-1:0] C_TRIG_LAST = TIM_W'(TRIG_LOW - 1);
   localparam logic [TIM_W-1:0] C_ARM_LAST  = TIM_W'(SYNC_STAGES - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_REQ       = 3'd1,
      ST_ARM       = 3'd2,
      ST_WAIT_EDGE = 3'd3,
      ST_XFER      = 3'd4
   } state_t;

   // ------------------------------------------------------------------
   // Input synchronisers plus one extra copy for edge detection
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
   logic                   r_sclk_d, r_cs_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
         r_sclk_d    <= 1'b0;
         r_cs_d      <= 1'b1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   spi_cs};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
         r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
      end
   end

   logic w_sclk, w_cs, w_mosi;
   logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;

   assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs        = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
   assign w_sclk_rise =  w_sclk & ~r_sclk_d;
   assign w_sclk_fall = ~w_sclk &  r_sclk_d;
   assign w_cs_fall   = ~w_cs   &  r_cs_d;
   assign w_cs_rise   =  w_cs   & ~r_cs_d;

   // ------------------------------------------------------------------
   // Receive path (runs regardless of the transmit FSM)
   // ------------------------------------------------------------------
   state_t             r_state, w_state_next;
   logic [CNT_W-1:0]   r_rx_cnt;
   logic [DATA_W-1:0]  r_rx_shift, w_rx_next;
   logic [DATA_W-1:0]  r_rx_data;
   logic               r_rx_valid, r_rx_is_read, r_rx_err;
   logic               w_rx_take, w_rx_last;

   assign w_rx_take = w_sclk_rise & ~w_cs;
   assign w_rx_last = w_rx_take & (r_rx_cnt == C_LAST_BIT);

   // Shift register with the incoming bit inserted at its LSB-first slot;
   // the completed word is taken from here so rx_data is not a cycle late.
   always_comb begin
      w_rx_next           = r_rx_shift;
      w_rx_next[r_rx_cnt] = w_mosi;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_cnt     <= '0;
         r_rx_shift   <= '0;
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_rx_is_read <= 1'b0;
         r_rx_err     <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         r_rx_err   <= 1'b0;
         if (w_cs_fall) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= '0;
         end else if (w_cs_rise) begin
            if (r_rx_cnt != '0)
               r_rx_err <= 1'b1;
            r_rx_cnt <= '0;
         end else if (w_rx_take) begin
            r_rx_shift <= w_rx_next;
            if (w_rx_last) begin
               r_rx_cnt     <= '0;
               r_rx_data    <= w_rx_next;
               r_rx_valid   <= 1'b1;
               r_rx_is_read <= (r_state == ST_XFER);
            end else begin
               r_rx_cnt <= r_rx_cnt + 1'b1;
            end
         end
      end
   end

   assign rx_data    = r_rx_data;
   assign rx_valid   = r_rx_valid;
   assign rx_is_read = r_rx_is_read;
   assign rx_err     = r_rx_err;

   // ------------------------------------------------------------------
   // Transmit FSM
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] r_tx_shift, w_tx_shift_next;
   logic [CNT_W-1:0]  r_tx_cnt,   w_tx_cnt_next;
   logic [TIM_W-1:0]  r_tim,      w_tim_next;
   logic              r_miso,     w_miso_next;
   logic              r_trig;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_tx_shift <= '0;
         r_tx_cnt   <= '0;
         r_tim      <= '0;
         r_miso     <= 1'b0;
         r_trig     <= 1'b1;
      end else begin
         r_state    <= w_state_next;
         r_tx_shift <= w_tx_shift_next;
         r_tx_cnt   <= w_tx_cnt_next;
         r_tim      <= w_tim_next;
         r_miso     <= w_miso_next;
         // Registered so the request pin stays glitch-free off-chip.
         r_trig     <= (w_state_next != ST_REQ);
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_tx_shift_next = r_tx_shift;
      w_tx_cnt_next   = r_tx_cnt;
      w_tim_next      = r_tim;
      w_miso_next     = r_miso;
      case (r_state)
         ST_IDLE: begin
            if (tx_valid) begin
               w_tx_shift_next = tx_data;
               w_tim_next      = '0;
               w_state_next    = ST_REQ;
            end
         end
         ST_REQ: begin
            if (r_tim == C_TRIG_LAST) begin
               w_tim_next   = '0;
               w_state_next = ST_ARM;
            end else begin
               w_tim_next = r_tim + 1'b1;
            end
         end
         // Lets sclk edges already in the synchroniser drain so a stale
         // falling edge cannot start the word early.
         ST_ARM: begin
            if (r_tim == C_ARM_LAST) begin
               w_tim_next   = '0;
               w_state_next = ST_WAIT_EDGE;
            end else begin
               w_tim_next = r_tim + 1'b1;
            end
         end
         ST_WAIT_EDGE: begin
            if (w_sclk_fall) begin
               w_miso_next   = r_tx_shift[DATA_W-1];
               w_tx_cnt_next = '0;
               w_state_next  = ST_XFER;
            end
         end
         ST_XFER: begin
            if (w_sclk_fall) begin
               if (r_tx_cnt == C_LAST_BIT) begin
                  // LSB was sampled on the preceding rise; park the line.
                  w_miso_next  = 1'b0;
                  w_state_next = ST_IDLE;
               end else begin
                  w_tx_shift_next = {r_tx_shift[DATA_W-2:0], 1'b0};
                  w_miso_next     = r_tx_shift[DATA_W-2];
                  w_tx_cnt_next   = r_tx_cnt + 1'b1;
               end
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign tx_ready     = (r_state == ST_IDLE);
   assign spi_miso     = r_miso;
   assign gpio_trigger = r_trig;

endmodule
`default_nettype wire

// File: tb/tb_spi_device.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_device
//  Purpose  : Self-checking bench for spi_device. Acts as the SPI controller
//             (free-running spi_clk, LSB-first writes, MSB-first reads on
//             request) and checks received words against an expectation
//             queue and transmitted words against the requested values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_device;

   localparam int DATA_W = 32;
   localparam int HALF   = 25;

   logic              clk, rst_n;
   logic              spi_clk, spi_cs, spi_mosi, spi_miso, gpio_trigger;
   logic [DATA_W-1:0] tx_data, rx_data;
   logic              tx_valid, tx_ready, rx_valid, rx_is_read, rx_err;

   spi_device #(.DATA_W(DATA_W), .SYNC_STAGES(2), .TRIG_LOW(6)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .spi_clk      (spi_clk),
      .spi_cs       (spi_cs),
      .spi_mosi     (spi_mosi),
      .spi_miso     (spi_miso),
      .gpio_trigger (gpio_trigger),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_is_read   (rx_is_read),
      .rx_err       (rx_err)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- clocks ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int ph = 0;
   initial spi_clk = 1'b0;
   always @(negedge clk) begin
      ph++;
      if (ph == HALF) begin
         ph      = 0;
         spi_clk = ~spi_clk;
      end
   end

   int rise_cnt = 0;
   always @(posedge spi_clk) rise_cnt++;

   // ---------------- model state ----------------
   logic [31:0] exp_q[$];
   int          exp_err  = 0;
   int          rd_first = -1000;   // index of first spi_clk rise of the latest read
   logic [31:0] model_rx = '0;

   // Receive-side compare: every cycle rx_data must equal the last word the
   // controller completed; each rx_valid consumes one expected word, and
   // rx_is_read is expected when the completing rise lies inside the read.
   always @(negedge clk) begin
      logic exp_rd;
      if (!rst_n) begin
         model_rx = '0;
      end else begin
         if (rx_valid) begin
            if (exp_q.size() == 0) begin
               chk("rx_valid_expected", exp_q.size(), 32'd1);
            end else begin
               model_rx = exp_q.pop_front();
               exp_rd   = (rise_cnt >= rd_first) && (rise_cnt <= rd_first + 31);
               chk("rx_is_read", 32'(rx_is_read), 32'(exp_rd));
            end
         end
         if (rx_err) begin
            chk("rx_err_expected", 32'(exp_err > 0), 32'd1);
            if (exp_err > 0) exp_err--;
         end
         chk("rx_data", rx_data, model_rx);
      end
   end

   // ---------------- controller tasks ----------------
   task automatic write_bits(input logic [31:0] w, input int n, input bit release_cs);
      if (spi_cs) @(negedge spi_clk);
      spi_cs = 1'b0;
      for (int i = 0; i < n; i++) begin
         spi_mosi = w[i];
         @(negedge spi_clk);
      end
      if (release_cs) spi_cs = 1'b1;
   endtask

   task automatic issue_tx(input logic [31:0] w);
      @(negedge spi_clk);
      chk("tx_ready_before_issue", 32'(tx_ready), 32'd1);
      tx_data  = w;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   // Waits for the request pulse and returns how many cycles it was low.
   task automatic wait_trigger(output int low_cycles);
      int n = 0;
      low_cycles = 0;
      while (gpio_trigger !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("trig_fall_seen", 32'(gpio_trigger), 32'd0);
      if (gpio_trigger !== 1'b0) return;
      while (gpio_trigger === 1'b0 && low_cycles < 50) begin
         low_cycles++;
         @(negedge clk);
      end
   endtask

   task automatic ctrl_read(input logic [31:0] w);
      int          n;
      logic [31:0] got = '0;
      wait_trigger(n);
      chk("trig_low_cycles", n, 32'd6);
      @(negedge spi_clk);
      rd_first = rise_cnt + 1;
      for (int i = 0; i < DATA_W; i++) begin
         @(posedge spi_clk);
         got = {got[30:0], spi_miso};
      end
      chk("miso_word", got, w);
      @(negedge spi_clk);
      repeat (6) @(negedge clk);
      chk("miso_idle_after_read", 32'(spi_miso), 32'd0);
      chk("tx_ready_after_read", 32'(tx_ready), 32'd1);
      chk("trig_high_after_read", 32'(gpio_trigger), 32'd1);
   endtask

   task automatic do_read(input logic [31:0] w);
      issue_tx(w);
      ctrl_read(w);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      rst_n    = 1'b0;
      spi_cs   = 1'b1;
      spi_mosi = 1'b0;
      tx_valid = 1'b0;
      tx_data  = '0;
      repeat (5) @(negedge clk);
      chk("rst_gpio_trigger", 32'(gpio_trigger), 32'd1);
      chk("rst_spi_miso",     32'(spi_miso),     32'd0);
      chk("rst_tx_ready",     32'(tx_ready),     32'd1);
      chk("rst_rx_data",      rx_data,           32'd0);
      chk("rst_rx_valid",     32'(rx_valid),     32'd0);
      chk("rst_rx_is_read",   32'(rx_is_read),   32'd0);
      chk("rst_rx_err",       32'(rx_err),       32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Plain write
      exp_q.push_back(32'hA5A5_0F0F);
      write_bits(32'hA5A5_0F0F, 32, 1'b1);
      repeat (10) @(negedge clk);
      chk("t1_rx_data", rx_data, 32'hA5A5_0F0F);
      chk("t1_rx_is_read", 32'(rx_is_read), 32'd0);

      // Plain read
      do_read(32'hDEAD_BEEF);

      // Back-to-back writes under one cs low
      exp_q.push_back(32'h0000_0001);
      exp_q.push_back(32'h8000_0000);
      write_bits(32'h0000_0001, 32, 1'b0);
      write_bits(32'h8000_0000, 32, 1'b1);
      repeat (10) @(negedge clk);
      chk("t3_rx_data", rx_data, 32'h8000_0000);
      chk("t3_queue_drained", exp_q.size(), 32'd0);

      // Partial word: cs rises after 10 bits
      exp_err++;
      write_bits(32'h0000_03FF, 10, 1'b1);
      repeat (10) @(negedge clk);
      chk("t4_rx_data_kept", rx_data, 32'h8000_0000);
      chk("t4_err_seen", exp_err, 32'd0);

      // Full duplex: write completes inside the read's shift window
      exp_q.push_back(32'hFFFF_0000);
      fork
         write_bits(32'hFFFF_0000, 32, 1'b1);
         do_read(32'h1234_5678);
      join
      repeat (10) @(negedge clk);
      chk("t5_rx_data", rx_data, 32'hFFFF_0000);
      chk("t5_rx_is_read", 32'(rx_is_read), 32'd1);

      // Reset in the middle of a read, then a fresh read
      issue_tx(32'hCAFE_F00D);
      wait_trigger(n);
      @(negedge spi_clk);
      repeat (5) @(posedge spi_clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_gpio_trigger", 32'(gpio_trigger), 32'd1);
      chk("t6_rst_spi_miso",     32'(spi_miso),     32'd0);
      chk("t6_rst_tx_ready",     32'(tx_ready),     32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      do_read(32'h0000_00FF);

      repeat (10) @(negedge clk);
      chk("end_queue_empty", exp_q.size(), 32'd0);
      chk("end_err_empty", exp_err, 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
